sine_sum_meas: RTL
==================

SINE_SUM_MEAS -- requirements
Module: sine_sum_meas

Interface
REQ-001 Parameter MID, default 4095: midpoint threshold of the 13-bit unsigned sample stream.
REQ-002 Parameter HYST, default 64: hysteresis half-width; legal range 1..2047, with MID-HYST >= 0 and MID+HYST <= 8191.
REQ-003 Port clk  input  1: single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset.
REQ-005 Port sample_en  input  1: qualifies sind_sum; a sample is accepted only on a clock edge where sample_en=1.
REQ-006 Port sind_sum  input  13: unsigned sample, 0..8191.
REQ-007 Port meas_valid  output  1: one-cycle pulse; a new measurement is present on the outputs.
REQ-008 Port period  output  16: accepted samples between consecutive rising crossings.
REQ-009 Port amp_max  output  13: largest sample in the measured period.
REQ-010 Port amp_min  output  13: smallest sample in the measured period.
REQ-011 Port ovf  output  1: set when the published period saturated.

Function
REQ-012 FSM states are S_INIT, S_LOW and S_HIGH; only accepted samples cause transitions.
REQ-013 S_INIT transitions to S_LOW on a sample <= MID-HYST; otherwise it stays in S_INIT.
REQ-014 S_LOW transitions to S_HIGH on a sample >= MID+HYST; that sample is a rising crossing.
REQ-015 S_HIGH transitions to S_LOW on a sample <= MID-HYST; no measurement is made on this transition.
REQ-016 Samples strictly inside the band (MID-HYST, MID+HYST) cause no state change.
REQ-017 An armed flag is set by the first rising crossing after reset; the first crossing publishes nothing.
REQ-018 At each rising crossing: cnt loads 1, and max/min load the crossing sample.
REQ-019 On each other accepted sample:
- cnt increments, saturating at 16'hFFFF;
- max and min update with the sample.
REQ-020 Rising crossing while armed:
- period, amp_max, amp_min load cnt, max, min as they stood before the crossing sample;
- ovf = (cnt == 16'hFFFF);
- meas_valid pulses.
REQ-021 Latency: meas_valid is high exactly in the cycle after the edge that accepts the crossing sample.
REQ-022 period, amp_max, amp_min and ovf hold their values between measurements.
REQ-023 sample_en=0 freezes the FSM, cnt, max and min, and suppresses meas_valid.
REQ-024 A saturated cnt is held, and the next crossing still publishes with ovf=1.

Reset
REQ-025 On rst=0 asynchronously:
- state=S_INIT; armed, cnt, max, min = 0;
- meas_valid, period, amp_max, amp_min, ovf = 0.
REQ-026 Reset mid-period discards all partial accumulation.
REQ-027 After reset, two further rising crossings are required before the next meas_valid.

Configuration
REQ-028 Macro SINE_SUM_MEAS_AVG_EN selects whether period is averaged.
REQ-029 Defined:
- period = (sum of the last 4 raw periods) >> 2, using an 18-bit accumulator;
- meas_valid fires only on every 4th armed crossing;
- amp_max/amp_min are the extremes over those 4 periods;
- ovf is set if any of the 4 periods saturated;
- reset clears the 4-period phase counter.
REQ-030 Undefined: every armed crossing publishes its raw period as in REQ-020.

Verification
REQ-031 Reset, then repeat the pattern 5x1000 followed by 5x7000 with sample_en=1 -> the first meas_valid occurs at the second rising crossing with period=10, amp_max=7000, amp_min=1000, ovf=0.
REQ-032 Same pattern with sample_en toggling 1,0 -> period=10; meas_valid is high only in the cycle after an accepted crossing.
REQ-033 Samples 4000/4100 alternating (inside the band) after reaching S_LOW -> no meas_valid, and outputs hold.
REQ-034 Sample 1000 for 70000 accepted samples, then 7000, then a pattern with period 10 -> one publish with period=16'hFFFF and ovf=1, then period=10 with ovf=0.
REQ-035 Assert rst low mid-period, then release -> all outputs are 0; the first meas_valid occurs after two further crossings.
REQ-036 With SINE_SUM_MEAS_AVG_EN defined, periods of 8,10,12,10 -> a single meas_valid with period=10.

Source files
------------

// File: rtl/sine_sum_meas.sv
// Period/amplitude meter for a 13-bit sample stream, using hysteresis-qualified rising crossings.
// Optional macro SINE_SUM_MEAS_AVG_EN publishes 4-period averages instead of raw periods.
module sine_sum_meas #(
  parameter int MID  = 4095,
  parameter int HYST = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [12:0] sind_sum,
  output logic        meas_valid,
  output logic [15:0] period,
  output logic [12:0] amp_max,
  output logic [12:0] amp_min,
  output logic        ovf
);

  localparam logic [12:0] LO_TH = 13'(MID - HYST);
  localparam logic [12:0] HI_TH = 13'(MID + HYST);

  typedef enum logic [1:0] {S_INIT, S_LOW, S_HIGH} state_t;

  state_t      state;
  logic        armed;
  logic [15:0] cnt;
  logic [12:0] max_val;
  logic [12:0] min_val;

  logic        is_low;
  logic        is_high;
  logic        rising;
  logic        cnt_sat;
  logic [15:0] cnt_inc;

  assign is_low  = (sind_sum <= LO_TH);
  assign is_high = (sind_sum >= HI_TH);
  assign rising  = (state == S_LOW) && is_high;
  assign cnt_sat = (cnt == 16'hFFFF);
  assign cnt_inc = cnt_sat ? cnt : cnt + 16'd1;

`ifdef SINE_SUM_MEAS_AVG_EN
  logic [1:0]  phase;
  logic [17:0] acc;
  logic [12:0] acc_max;
  logic [12:0] acc_min;
  logic        acc_ovf;
  logic [17:0] sum_next;
  logic [12:0] blk_max;
  logic [12:0] blk_min;
  logic        blk_ovf;

  // Phase 0 starts a fresh block, so the accumulated extremes are ignored there.
  assign sum_next = acc + {2'b00, cnt};
  assign blk_max  = (phase != 2'd0 && acc_max > max_val) ? acc_max : max_val;
  assign blk_min  = (phase != 2'd0 && acc_min < min_val) ? acc_min : min_val;
  assign blk_ovf  = (phase != 2'd0 && acc_ovf) || cnt_sat;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_INIT;
      armed      <= 1'b0;
      cnt        <= 16'd0;
      max_val    <= 13'd0;
      min_val    <= 13'd0;
      meas_valid <= 1'b0;
      period     <= 16'd0;
      amp_max    <= 13'd0;
      amp_min    <= 13'd0;
      ovf        <= 1'b0;
`ifdef SINE_SUM_MEAS_AVG_EN
      phase      <= 2'd0;
      acc        <= 18'd0;
      acc_max    <= 13'd0;
      acc_min    <= 13'd0;
      acc_ovf    <= 1'b0;
`endif
    end else begin
      meas_valid <= 1'b0;
      if (sample_en) begin
        if (rising) begin
          state   <= S_HIGH;
          armed   <= 1'b1;
          cnt     <= 16'd1;
          max_val <= sind_sum;
          min_val <= sind_sum;
          if (armed) begin
`ifdef SINE_SUM_MEAS_AVG_EN
            phase   <= phase + 2'd1;
            acc_max <= blk_max;
            acc_min <= blk_min;
            acc_ovf <= blk_ovf;
            if (phase == 2'd3) begin
              acc        <= 18'd0;
              period     <= sum_next[17:2];
              amp_max    <= blk_max;
              amp_min    <= blk_min;
              ovf        <= blk_ovf;
              meas_valid <= 1'b1;
            end else begin
              acc <= sum_next;
            end
`else
            period     <= cnt;
            amp_max    <= max_val;
            amp_min    <= min_val;
            ovf        <= cnt_sat;
            meas_valid <= 1'b1;
`endif
          end
        end else begin
          cnt <= cnt_inc;
          if (sind_sum > max_val) max_val <= sind_sum;
          if (sind_sum < min_val) min_val <= sind_sum;
          case (state)
            S_INIT:  if (is_low) state <= S_LOW;
            S_HIGH:  if (is_low) state <= S_LOW;
            default: state <= state;
          endcase
        end
      end
    end
  end

endmodule
